// File: rtl/patdet_pkg.sv
// Shared constants for the serial pattern detector: reset pattern and length.
package patdet_pkg;

  localparam logic [31:0] DEFAULT_PAT = 32'b1010;
  localparam int          DEFAULT_LEN = 4;

  function automatic int clamp_len(input int len, input int max_len);
    return (len > max_len) ? max_len : len;
  endfunction

endpackage

// File: rtl/patdet_history.sv
// Serial history shift register with a saturating count of valid bits.
module patdet_history #(
  parameter int MAX_LEN = 8,
  parameter int FILL_W  = $clog2(MAX_LEN + 1)
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               i_shift,
  input  logic               i_bit,
  input  logic               i_clear,
  output logic [MAX_LEN-1:0] o_hist,
  output logic [FILL_W-1:0]  o_fill
);

  logic [MAX_LEN-1:0] r_hist;
  logic [FILL_W-1:0]  r_fill;

  // NOTE: non-blocking assignments so every flop updates from pre-edge values.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_hist <= '0;
      r_fill <= '0;
    end else if (i_clear) begin
      r_hist <= '0;
      r_fill <= '0;
    end else if (i_shift) begin
      r_hist <= {r_hist[MAX_LEN-2:0], i_bit};
      if (r_fill != FILL_W'(MAX_LEN)) r_fill <= r_fill + FILL_W'(1);
    end
  end

  assign o_hist = r_hist;
  assign o_fill = r_fill;

endmodule

// File: rtl/pattern_detector.sv
// Serial pattern detector with programmable pattern/length and overlap control.
// Optional match counter enabled by defining PATDET_MATCH_COUNT_EN.
module pattern_detector #(
  parameter  int MAX_LEN = 8,
  parameter  int CNT_W   = 8,
  localparam int LEN_W   = $clog2(MAX_LEN + 1)
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               in,
  input  logic               in_valid,
  input  logic               pat_load,
  input  logic [MAX_LEN-1:0] pat_data,
  input  logic [LEN_W-1:0]   pat_len,
  input  logic               overlap,
  output logic               out,
  output logic [CNT_W-1:0]   match_count
);

  import patdet_pkg::*;

  logic [MAX_LEN-1:0] r_pat;
  logic [LEN_W-1:0]   r_len;
  logic               r_out;

  logic [MAX_LEN-1:0] w_hist;
  logic [LEN_W-1:0]   w_fill;
  logic [MAX_LEN-1:0] w_new_hist;
  logic [MAX_LEN-1:0] w_mask;
  logic [LEN_W-1:0]   w_load_len;
  logic               w_len_ok;
  logic               w_match;
  logic               w_clear;
  logic               w_unused_msb;

  patdet_history #(
    .MAX_LEN (MAX_LEN),
    .FILL_W  (LEN_W)
  ) u_history (
    .clk     (clk),
    .reset   (reset),
    .i_shift (in_valid),
    .i_bit   (in),
    .i_clear (w_clear),
    .o_hist  (w_hist),
    .o_fill  (w_fill)
  );

  // The oldest history bit shifts out before it can ever be compared.
  assign w_unused_msb = w_hist[MAX_LEN-1];
  assign w_new_hist   = {w_hist[MAX_LEN-2:0], in};

  // NOTE: give every always_comb output a default first so no path infers a latch.
  always_comb begin
    w_mask = '0;
    for (int i = 0; i < MAX_LEN; i++) w_mask[i] = (i < int'(r_len));
  end

  assign w_len_ok   = (r_len != '0) &&
                      (({1'b0, w_fill} + (LEN_W+1)'(1)) >= {1'b0, r_len});
  assign w_match    = in_valid && !pat_load && w_len_ok &&
                      (((w_new_hist ^ r_pat) & w_mask) == '0);
  assign w_clear    = pat_load || (w_match && !overlap);
  assign w_load_len = (pat_len > LEN_W'(MAX_LEN)) ? LEN_W'(MAX_LEN) : pat_len;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_pat <= DEFAULT_PAT[MAX_LEN-1:0];
      r_len <= LEN_W'(clamp_len(DEFAULT_LEN, MAX_LEN));
      r_out <= 1'b0;
    end else begin
      r_out <= w_match;
      if (pat_load) begin
        r_pat <= pat_data;
        r_len <= w_load_len;
      end
    end
  end

  assign out = r_out;

`ifdef PATDET_MATCH_COUNT_EN
  logic [CNT_W-1:0] r_count;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_count <= '0;
    end else if (pat_load) begin
      r_count <= '0;
    end else if (w_match && (r_count != '1)) begin
      r_count <= r_count + CNT_W'(1);
    end
  end

  assign match_count = r_count;
`else
  assign match_count = '0;
`endif

endmodule

// File: tb/tb_pattern_detector.sv
// Randomized self-checking bench for pattern_detector against a queue-based model.
module tb_pattern_detector;

  localparam int MAX_LEN = 8;
  localparam int LEN_W   = 4;
`ifdef PATDET_MATCH_COUNT_EN
  localparam bit CNT_EN = 1'b1;
`else
  localparam bit CNT_EN = 1'b0;
`endif

  logic               clk = 1'b0;
  logic               reset;
  logic               in_bit;
  logic               in_valid;
  logic               pat_load;
  logic [MAX_LEN-1:0] pat_data;
  logic [LEN_W-1:0]   pat_len;
  logic               overlap;
  logic               out_a;
  logic               out_b;
  logic [7:0]         cnt_a;
  logic [1:0]         cnt_b;

  int n_checks = 0;
  int n_errors = 0;

  // Reference model state: bits sampled since the last clear, oldest first.
  bit               hist_q[$];
  logic [MAX_LEN-1:0] m_pat;
  int               m_len;
  bit               m_out;
  int               m_cnt;

  always #5 clk = ~clk;

  pattern_detector #(.MAX_LEN(MAX_LEN), .CNT_W(8)) u_dut_a (
    .clk (clk), .reset (reset), .in (in_bit), .in_valid (in_valid),
    .pat_load (pat_load), .pat_data (pat_data), .pat_len (pat_len),
    .overlap (overlap), .out (out_a), .match_count (cnt_a)
  );

  pattern_detector #(.MAX_LEN(MAX_LEN), .CNT_W(2)) u_dut_b (
    .clk (clk), .reset (reset), .in (in_bit), .in_valid (in_valid),
    .pat_load (pat_load), .pat_data (pat_data), .pat_len (pat_len),
    .overlap (overlap), .out (out_b), .match_count (cnt_b)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic int exp_cnt(input int sat);
    if (!CNT_EN) return 0;
    return (m_cnt > sat) ? sat : m_cnt;
  endfunction

  task automatic model_reset();
    hist_q.delete();
    m_pat = MAX_LEN'(4'b1010);
    m_len = 4;
    m_out = 1'b0;
    m_cnt = 0;
  endtask

  task automatic model_edge();
    bit hit;
    if (pat_load) begin
      m_pat = pat_data;
      m_len = (int'(pat_len) > MAX_LEN) ? MAX_LEN : int'(pat_len);
      hist_q.delete();
      m_cnt = 0;
      m_out = 1'b0;
    end else if (in_valid) begin
      hist_q.push_back(in_bit);
      if (hist_q.size() > MAX_LEN) void'(hist_q.pop_front());
      hit = (m_len > 0) && (hist_q.size() >= m_len);
      for (int k = 0; k < m_len && hit; k++)
        if (hist_q[hist_q.size()-1-k] != m_pat[k]) hit = 1'b0;
      m_out = hit;
      if (hit) begin
        m_cnt++;
        if (!overlap) hist_q.delete();
      end
    end else begin
      m_out = 1'b0;
    end
  endtask

  task automatic check_all(input string tag);
    check({tag, "_out_a"}, 32'(out_a), 32'(m_out));
    check({tag, "_out_b"}, 32'(out_b), 32'(m_out));
    check({tag, "_cnt_a"}, 32'(cnt_a), 32'(exp_cnt(255)));
    check({tag, "_cnt_b"}, 32'(cnt_b), 32'(exp_cnt(3)));
  endtask

  task automatic step(input logic b, input logic v, input logic ld, input logic ov,
                      input logic [MAX_LEN-1:0] d, input logic [LEN_W-1:0] l,
                      input string tag);
    @(negedge clk);
    in_bit = b; in_valid = v; pat_load = ld; overlap = ov; pat_data = d; pat_len = l;
    @(posedge clk);
    model_edge();
    #1;
    check_all(tag);
  endtask

  task automatic send_bits(input logic [31:0] bits, input int n, input logic ov,
                           input string tag);
    for (int i = n - 1; i >= 0; i--) step(bits[i], 1'b1, 1'b0, ov, pat_data, pat_len, tag);
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1; in_valid = 1'b0; pat_load = 1'b0;
    #1;
    model_reset();
    check_all("rst");
    @(negedge clk);
    reset = 1'b0;
  endtask

  // Assert reset between edges and confirm outputs drop with no clock edge.
  task automatic mid_cycle_reset(input string tag);
    #1;
    reset = 1'b1;
    #1;
    model_reset();
    check_all(tag);
    @(negedge clk);
    reset = 1'b0;
  endtask

  initial begin
    reset = 1'b1; in_bit = 1'b0; in_valid = 1'b0; pat_load = 1'b0;
    pat_data = '0; pat_len = '0; overlap = 1'b1;
    model_reset();

    // Default pattern 1010, overlapping: pulses after bits 4 and 6.
    do_reset();
    send_bits(32'b101010, 6, 1'b1, "ov1");
    check("ov1_total", 32'(cnt_a), CNT_EN ? 32'd2 : 32'd0);

    // Same stream without overlap: single pulse after bit 4.
    do_reset();
    send_bits(32'b101010, 6, 1'b0, "ov0");
    check("ov0_total", 32'(cnt_a), CNT_EN ? 32'd1 : 32'd0);

    // Pattern 110, len 3: pulses after bits 4 and 7.
    step(1'b0, 1'b0, 1'b1, 1'b1, MAX_LEN'(3'b110), LEN_W'(3), "ld110");
    send_bits(32'b1110110, 7, 1'b1, "p110");
    check("p110_total", 32'(cnt_a), CNT_EN ? 32'd2 : 32'd0);

    // Length above MAX_LEN clamps to MAX_LEN.
    step(1'b0, 1'b0, 1'b1, 1'b1, 8'b10110011, LEN_W'(15), "ldclamp");
    send_bits(32'b10110011, 8, 1'b1, "clamp");

    // Load and sample on the same edge: the bit is dropped.
    step(1'b1, 1'b1, 1'b1, 1'b1, MAX_LEN'(4'b1010), LEN_W'(4), "collide");
    send_bits(32'b010, 3, 1'b1, "postcol");
    send_bits(32'b10, 2, 1'b1, "postcol2");

    // Six overlapping matches saturate the 2-bit counter at 3.
    do_reset();
    send_bits(32'b101010101010101, 15, 1'b1, "sat");
    check("sat_b", 32'(cnt_b), CNT_EN ? 32'd3 : 32'd0);

    // Reset between edges while out is high.
    do_reset();
    send_bits(32'b1010, 4, 1'b1, "pre_arst");
    check("arst_pulse", 32'(out_a), 32'd1);
    mid_cycle_reset("arst_hi");

    // Reset after a partial 1,0,1: the partial match is discarded.
    send_bits(32'b101, 3, 1'b1, "part");
    mid_cycle_reset("arst_part");
    send_bits(32'b0, 1, 1'b1, "after_arst");

    // Zero length never matches.
    step(1'b0, 1'b0, 1'b1, 1'b1, 8'h00, LEN_W'(0), "ld0");
    for (int i = 0; i < 12; i++) step(1'($urandom), 1'b1, 1'b0, 1'b1, pat_data, pat_len, "len0");

    // Randomized traffic.
    for (int i = 0; i < 3000; i++) begin
      logic ld;
      logic [LEN_W-1:0] l;
      ld = ($urandom_range(0, 99) < 3);
      l  = ($urandom_range(0, 1) == 0) ? LEN_W'($urandom_range(1, 4))
                                       : LEN_W'($urandom_range(0, 15));
      step(1'($urandom), ($urandom_range(0, 3) != 0), ld, 1'($urandom),
           ld ? MAX_LEN'($urandom) : pat_data, ld ? l : pat_len, "rand");
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
